mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Consumer end of the EX/MEM pipeline register: the MEM stage of the pipelined CPU.
//  Turns EX/MEM control and data into a valid/ack transaction on a variable-latency data memory.
//  Stalls the upstream pipeline while an access is outstanding.
//  Registers the stage result into the MEM/WB register for the write-back stage.
// PARAMETERS
//  WORD_W       16  data/address width (equals WORD_LEN)
//  INSTR_W      19  instruction width (equals INSTRUCTION_LEN)
//  TIMEOUT_CYC  15  max ACCESS cycles without ack (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        reset, asynchronous, active-high
//  ex_valid        in   1        EX/MEM holds a real instruction (0 = bubble)
//  ex_alu_out      in   WORD_W   ALU result; memory address for load/store
//  ex_rf_out2      in   WORD_W   store data
//  ex_instruction  in   INSTR_W  instruction word
//  ex_mem_read     in   1        load
//  ex_mem_write    in   1        store
//  ex_rf_write_en  in   1        write-back enable
//  ex_sel_wb_alu   in   1        WB source = ALU
//  ex_sel_wb_mem   in   1        WB source = memory
//  mem_stall       out  1        combinational; freezes PC, IF/ID, ID/EX, EX/MEM
//  dm_req          out  1        memory request, registered
//  dm_we           out  1        1 = write, registered
//  dm_addr         out  WORD_W   registered address
//  dm_wdata        out  WORD_W   registered write data
//  dm_ack          in   1        memory done; sampled only in MS_ACCESS
//  dm_rdata        in   WORD_W   read data, valid when dm_ack=1
//  wb_valid        out  1        MEM/WB holds a real instruction
//  wb_alu_out      out  WORD_W   MEM/WB ALU result
//  wb_mem_data     out  WORD_W   MEM/WB load data (0 for non-loads)
//  wb_instruction  out  INSTR_W  MEM/WB instruction word
//  wb_rf_write_en  out  1        MEM/WB write-back enable
//  wb_sel_wb_alu   out  1        MEM/WB source select: ALU
//  wb_sel_wb_mem   out  1        MEM/WB source select: memory
//  mem_err         out  1        sticky timeout flag (tied 0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state MS_IDLE; every registered output 0; mem_stall 0 (its inputs are 0).
//  memop = ex_valid & (ex_mem_read | ex_mem_write).
//  Write has priority: if both read and write are set, the access is a write and wb_mem_data = 0.
//  MS_IDLE, memop=0:
//   - mem_stall = 0.
//   - MEM/WB loads ex_* at the edge; wb_mem_data = 0; wb_valid = ex_valid.
//   - If ex_valid = 0, all wb_* control bits load as 0.
//   - Latency: 1 cycle.
//  MS_IDLE, memop=1:
//   - mem_stall = 1.
//   - At the edge: dm_req <= 1; dm_we <= ex_mem_write; dm_addr <= ex_alu_out; dm_wdata <= ex_rf_out2.
//   - MEM/WB loads a bubble (all wb_* = 0); state -> MS_ACCESS.
//  MS_ACCESS, dm_ack=0:
//   - mem_stall = 1; dm_* held stable; MEM/WB holds the bubble.
//  MS_ACCESS, dm_ack=1:
//   - mem_stall = 0, so EX/MEM advances at this same edge.
//   - At the edge: dm_req <= 0; MEM/WB loads ex_* with wb_mem_data <= dm_rdata for a read (0 for a write).
//   - wb_valid <= 1; state -> MS_IDLE.
//  Load/store latency: 2 + N cycles, where N = cycles from dm_req rising to dm_ack.
//   A 0-wait memory (ack in the first ACCESS cycle) gives 2 cycles.
//  Back-to-back memops: the next request issues one cycle after the ack (IDLE issue cycle).
//  dm_ack outside MS_ACCESS is ignored.
//  Reset during MS_ACCESS aborts: dm_req drops immediately; memory must tolerate the abandoned request.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - 4-bit counter clears on entry to MS_ACCESS and increments each ACCESS cycle without ack.
//   - When the count reaches TIMEOUT_CYC without ack, that cycle: mem_stall = 0.
//   - At that edge: dm_req <= 0; mem_err <= 1 (sticky until rst).
//   - MEM/WB loads ex_* with wb_mem_data = 0 and wb_rf_write_en forced to 0; state -> MS_IDLE.
//   - Ack on the same cycle as timeout: the ack wins, no error.
//  MEM_TIMEOUT_EN undefined: no counter; MS_ACCESS waits indefinitely; mem_err tied 0.
// STRUCTURE
//  Package ca4_pipe_pkg:
//   - mem_state_e {MS_IDLE, MS_ACCESS}.
//   - WORD_W / INSTR_W defaults.
//   - struct wb_ctrl_t {rf_write_en, sel_wb_alu, sel_wb_mem}.
//  Sub-module mem_wb_reg: MEM/WB register with load and bubble inputs, async reset.
//  FSM, dm_* registers and timeout counter stay in mem_access_stage.
// TESTING
//  1 ALU op: ex_valid=1, alu_out=0x1234, rf_write_en=1 -> next cycle wb_alu_out=0x1234, wb_valid=1, mem_stall never 1.
//  2 Load, 0-wait: read at addr 0x0040, ack in the first ACCESS cycle with rdata=0xBEEF
//    -> stall high 1 cycle, dm_addr=0x0040, dm_we=0; wb_mem_data=0xBEEF, wb_valid=1, 2-cycle latency.
//  3 Store, 3 wait cycles: write addr 0x0010, data 0x00AA
//    -> dm_req/dm_we/addr/data stable 4 cycles, stall high 4 cycles; then dm_req=0, wb_mem_data=0, one bubble before the result.
//  4 Back-to-back loads with ack after 1 cycle each -> 2 dm_req pulses separated by exactly 1 low cycle; both results in order.
//  5 rst pulse mid-ACCESS -> dm_req=0, all wb_*=0, state MS_IDLE, no spurious write-back after reset release.
//  6 (MEM_TIMEOUT_EN) no ack for 15 ACCESS cycles -> mem_err=1, dm_req=0, wb_rf_write_en=0, pipeline resumes;
//    ack and timeout in the same cycle -> mem_err stays 0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the CA4 pipeline MEM stage: FSM states, MEM/WB control bundle,
// and default datapath widths.
package ca4_pipe_pkg;

  localparam int WORD_W_DEF  = 16;
  localparam int INSTR_W_DEF = 19;

  typedef enum logic {
    MS_IDLE,
    MS_ACCESS
  } mem_state_e;

  typedef struct packed {
    logic rf_write_en;
    logic sel_wb_alu;
    logic sel_wb_mem;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory valid/ack bus. The MEM stage is the master, the memory the slave.
interface mem_access_stage_if
  import ca4_pipe_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);

  logic              dm_req;
  logic              dm_we;
  logic [WORD_W-1:0] dm_addr;
  logic [WORD_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [WORD_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );

endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears every field and wins over load;
// with neither asserted the register holds.
module mem_wb_reg
  import ca4_pipe_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic               valid_i,
  input  logic [WORD_W-1:0]  alu_i,
  input  logic [WORD_W-1:0]  mem_data_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  wb_ctrl_t           ctrl_i,
  output logic               valid_o,
  output logic [WORD_W-1:0]  alu_o,
  output logic [WORD_W-1:0]  mem_data_o,
  output logic [INSTR_W-1:0] instr_o,
  output wb_ctrl_t           ctrl_o
);

  logic               valid_q;
  logic [WORD_W-1:0]  alu_q;
  logic [WORD_W-1:0]  mem_data_q;
  logic [INSTR_W-1:0] instr_q;
  wb_ctrl_t           ctrl_q;

  // Register update: reset/bubble clear, load captures, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      mem_data_q <= '0;
      instr_q    <= '0;
      ctrl_q     <= '0;
    end else if (bubble_i) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      mem_data_q <= '0;
      instr_q    <= '0;
      ctrl_q     <= '0;
    end else if (load_i) begin
      valid_q    <= valid_i;
      alu_q      <= alu_i;
      mem_data_q <= mem_data_i;
      instr_q    <= instr_i;
      ctrl_q     <= ctrl_i;
    end
  end

  assign valid_o    = valid_q;
  assign alu_o      = alu_q;
  assign mem_data_o = mem_data_q;
  assign instr_o    = instr_q;
  assign ctrl_o     = ctrl_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the CA4 pipeline: issues loads/stores on the valid/ack data-memory
// bus, stalls upstream while an access is outstanding, and fills MEM/WB.
// Optional feature: define MEM_TIMEOUT_EN to abandon accesses that see no ack
// within TIMEOUT_CYC cycles and raise the sticky mem_err flag.
//
//   state     | meaning
//   MS_IDLE   | no access outstanding; ALU ops pass straight to MEM/WB
//   MS_ACCESS | request on the bus, waiting for dm_ack (MEM/WB holds a bubble)
module mem_access_stage
  import ca4_pipe_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [WORD_W-1:0]     ex_alu_out,
  input  logic [WORD_W-1:0]     ex_rf_out2,
  input  logic [INSTR_W-1:0]    ex_instruction,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_rf_write_en,
  input  logic                  ex_sel_wb_alu,
  input  logic                  ex_sel_wb_mem,
  output logic                  mem_stall,
  mem_access_stage_if.master    dm,
  output logic                  wb_valid,
  output logic [WORD_W-1:0]     wb_alu_out,
  output logic [WORD_W-1:0]     wb_mem_data,
  output logic [INSTR_W-1:0]    wb_instruction,
  output logic                  wb_rf_write_en,
  output logic                  wb_sel_wb_alu,
  output logic                  wb_sel_wb_mem,
  output logic                  mem_err
);

  mem_state_e        state_q, state_d;
  logic              memop;
  logic              dm_issue, dm_done;
  logic              wb_load, wb_bubble;
  logic [WORD_W-1:0] wb_mem_data_d;
  wb_ctrl_t          wb_ctrl_d, wb_ctrl_q;

  logic              dm_req_q;
  logic              dm_we_q;
  logic [WORD_W-1:0] dm_addr_q;
  logic [WORD_W-1:0] dm_wdata_q;

  assign memop = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_TIMEOUT_EN
  logic [3:0] to_cnt_q;
  logic       timeout_hit;
  logic       err_set;
  logic       mem_err_q;

  assign timeout_hit = (state_q == MS_ACCESS) && (to_cnt_q == 4'(TIMEOUT_CYC - 1));
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MS_IDLE;
    else     state_q <= state_d;
  end

  // Next state, stall and MEM/WB load control. Ack is checked before timeout so
  // an ack arriving in the timeout cycle completes normally.
  always_comb begin
    state_d       = state_q;
    mem_stall     = 1'b0;
    dm_issue      = 1'b0;
    dm_done       = 1'b0;
    wb_load       = 1'b0;
    wb_bubble     = 1'b0;
    wb_mem_data_d = '0;
    wb_ctrl_d     = '{rf_write_en: ex_rf_write_en & ex_valid,
                      sel_wb_alu:  ex_sel_wb_alu  & ex_valid,
                      sel_wb_mem:  ex_sel_wb_mem  & ex_valid};
`ifdef MEM_TIMEOUT_EN
    err_set       = 1'b0;
`endif
    case (state_q)
      MS_IDLE: begin
        if (memop) begin
          mem_stall = 1'b1;
          dm_issue  = 1'b1;
          wb_bubble = 1'b1;
          state_d   = MS_ACCESS;
        end else begin
          wb_load   = 1'b1;
        end
      end
      MS_ACCESS: begin
        if (dm.dm_ack) begin
          wb_load       = 1'b1;
          dm_done       = 1'b1;
          wb_mem_data_d = ex_mem_write ? '0 : dm.dm_rdata;
          state_d       = MS_IDLE;
`ifdef MEM_TIMEOUT_EN
        end else if (timeout_hit) begin
          wb_load               = 1'b1;
          dm_done               = 1'b1;
          err_set               = 1'b1;
          wb_ctrl_d.rf_write_en = 1'b0;
          state_d               = MS_IDLE;
`endif
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // Bus request registers: captured at issue, held until ack (or timeout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
    end else if (dm_issue) begin
      dm_req_q   <= 1'b1;
      dm_we_q    <= ex_mem_write;
      dm_addr_q  <= ex_alu_out;
      dm_wdata_q <= ex_rf_out2;
    end else if (dm_done) begin
      dm_req_q   <= 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Wait counter (cleared at issue) and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (dm_issue)                                   to_cnt_q <= '0;
      else if (state_q == MS_ACCESS && !dm.dm_ack)    to_cnt_q <= to_cnt_q + 4'd1;
      if (err_set)                                    mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;

  mem_wb_reg #(
    .WORD_W  (WORD_W),
    .INSTR_W (INSTR_W)
  ) u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wb_load),
    .bubble_i   (wb_bubble),
    .valid_i    (ex_valid),
    .alu_i      (ex_alu_out),
    .mem_data_i (wb_mem_data_d),
    .instr_i    (ex_instruction),
    .ctrl_i     (wb_ctrl_d),
    .valid_o    (wb_valid),
    .alu_o      (wb_alu_out),
    .mem_data_o (wb_mem_data),
    .instr_o    (wb_instruction),
    .ctrl_o     (wb_ctrl_q)
  );

  assign wb_rf_write_en = wb_ctrl_q.rf_write_en;
  assign wb_sel_wb_alu  = wb_ctrl_q.sel_wb_alu;
  assign wb_sel_wb_mem  = wb_ctrl_q.sel_wb_mem;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB contents (and the cycle
// they must appear in) are queued when an instruction is driven and checked when
// wb_valid rises. Bus and stall behaviour is checked inline by the driver.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_alu_out = '0;
  logic [15:0] ex_rf_out2 = '0;
  logic [18:0] ex_instruction = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_rf_write_en = 1'b0;
  logic        ex_sel_wb_alu = 1'b0;
  logic        ex_sel_wb_mem = 1'b0;
  logic        mem_stall;
  logic        wb_valid;
  logic [15:0] wb_alu_out;
  logic [15:0] wb_mem_data;
  logic [18:0] wb_instruction;
  logic        wb_rf_write_en;
  logic        wb_sel_wb_alu;
  logic        wb_sel_wb_mem;
  logic        mem_err;

  mem_access_stage_if #(.WORD_W(16)) dm_bus ();

  mem_access_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_alu_out     (ex_alu_out),
    .ex_rf_out2     (ex_rf_out2),
    .ex_instruction (ex_instruction),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_rf_write_en (ex_rf_write_en),
    .ex_sel_wb_alu  (ex_sel_wb_alu),
    .ex_sel_wb_mem  (ex_sel_wb_mem),
    .mem_stall      (mem_stall),
    .dm             (dm_bus.master),
    .wb_valid       (wb_valid),
    .wb_alu_out     (wb_alu_out),
    .wb_mem_data    (wb_mem_data),
    .wb_instruction (wb_instruction),
    .wb_rf_write_en (wb_rf_write_en),
    .wb_sel_wb_alu  (wb_sel_wb_alu),
    .wb_sel_wb_mem  (wb_sel_wb_mem),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu;
    logic [15:0] md;
    logic [18:0] ins;
    logic        rfwe;
    logic        sa;
    logic        sm;
    int          cyc;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  cyc = 0;
  int  n_vec = 0;
  int  n_mis = 0;

`ifdef MEM_TIMEOUT_EN
  localparam logic EXP_ERR_END = 1'b1;
`else
  localparam logic EXP_ERR_END = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: compare MEM/WB against the scoreboard, bubbles must carry no control.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", wb_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          chk("wb_alu_out",     wb_alu_out,     mon_e.alu);
          chk("wb_mem_data",    wb_mem_data,    mon_e.md);
          chk("wb_instruction", wb_instruction, mon_e.ins);
          chk("wb_rf_write_en", wb_rf_write_en, mon_e.rfwe);
          chk("wb_sel_wb_alu",  wb_sel_wb_alu,  mon_e.sa);
          chk("wb_sel_wb_mem",  wb_sel_wb_mem,  mon_e.sm);
          chk("wb_cycle",       cyc,            mon_e.cyc);
        end
      end else begin
        chk("bubble_ctrl", {wb_rf_write_en, wb_sel_wb_alu, wb_sel_wb_mem}, 3'b000);
      end
    end
  end

  task automatic clear_ex();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_rf_write_en = 0; ex_sel_wb_alu = 0; ex_sel_wb_mem = 0;
  endtask

  // Drive one EX/MEM entry (called #1 after a rising edge) and act as a memory
  // that acks after wt wait cycles.
  task automatic do_op(input logic v, input logic [15:0] alu, input logic [15:0] rf2,
                       input logic [18:0] ins, input logic rd, input logic wr,
                       input logic rfwe, input logic sa, input logic sm,
                       input int wt, input logic [15:0] rdat);
    logic memop;
    sb_t  e;
    memop = v & (rd | wr);
    ex_valid = v; ex_alu_out = alu; ex_rf_out2 = rf2; ex_instruction = ins;
    ex_mem_read = rd; ex_mem_write = wr; ex_rf_write_en = rfwe;
    ex_sel_wb_alu = sa; ex_sel_wb_mem = sm;
    if (v) begin
      e.alu = alu; e.md = (memop && !wr) ? rdat : 16'h0000; e.ins = ins;
      e.rfwe = rfwe; e.sa = sa; e.sm = sm;
      e.cyc = cyc + (memop ? 2 + wt : 1);
      sb.push_back(e);
    end
    #1;
    chk("stall_issue", mem_stall, memop);
    @(posedge clk); #1;
    if (memop) begin
      for (int i = 0; i <= wt; i++) begin
        chk("dm_req",   dm_bus.dm_req,   1'b1);
        chk("dm_we",    dm_bus.dm_we,    wr);
        chk("dm_addr",  dm_bus.dm_addr,  alu);
        chk("dm_wdata", dm_bus.dm_wdata, rf2);
        if (i < wt) begin
          chk("stall_wait", mem_stall, 1'b1);
          dm_bus.dm_rdata = 16'hDEAD;
          @(posedge clk); #1;
        end
      end
      dm_bus.dm_ack = 1'b1;
      dm_bus.dm_rdata = rdat;
      #1;
      chk("stall_ack", mem_stall, 1'b0);
      @(posedge clk); #1;
      dm_bus.dm_ack = 1'b0;
      chk("dm_req_drop", dm_bus.dm_req, 1'b0);
    end
    clear_ex();
  endtask

  task automatic idle(input int n);
    clear_ex();
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    dm_bus.dm_ack = 1'b0;
    dm_bus.dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req",   dm_bus.dm_req,  1'b0);
    chk("rst_dm_addr",  dm_bus.dm_addr, 16'h0000);
    chk("rst_wb_valid", wb_valid,       1'b0);
    chk("rst_mem_err",  mem_err,        1'b0);
    chk("rst_stall",    mem_stall,      1'b0);
    rst = 1'b0;
    idle(1);

    // ALU op, then a bubble carrying a stray write-enable.
    do_op(1, 16'h1234, 16'h0, 19'h00111, 0, 0, 1, 1, 0, 0, 16'h0);
    do_op(0, 16'h5555, 16'h0, 19'h00222, 0, 0, 1, 1, 0, 0, 16'h0);
    idle(2);
    // Load, zero wait states.
    do_op(1, 16'h0040, 16'h0, 19'h00333, 1, 0, 1, 0, 1, 0, 16'hBEEF);
    idle(2);
    // Store, three wait states.
    do_op(1, 16'h0010, 16'h00AA, 19'h00444, 0, 1, 0, 0, 0, 3, 16'h7777);
    idle(2);
    // Back-to-back loads, one wait each, then an ALU op directly after.
    do_op(1, 16'h0100, 16'h0, 19'h00555, 1, 0, 1, 0, 1, 1, 16'hA001);
    do_op(1, 16'h0102, 16'h0, 19'h00666, 1, 0, 1, 0, 1, 1, 16'hA002);
    do_op(1, 16'h0ABC, 16'h0, 19'h00777, 0, 0, 1, 1, 0, 0, 16'h0);
    idle(2);
    // Read and write both set: write wins, no load data.
    do_op(1, 16'h0020, 16'h0F0F, 19'h00888, 1, 1, 1, 0, 1, 2, 16'h1111);
    idle(2);

    // Reset in the middle of an access.
    ex_valid = 1; ex_mem_read = 1; ex_alu_out = 16'h0080; ex_rf_write_en = 1; ex_sel_wb_mem = 1;
    @(posedge clk); #1;
    chk("pre_rst_req", dm_bus.dm_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_dm_req",   dm_bus.dm_req,  1'b0);
    chk("abort_wb_valid", wb_valid,       1'b0);
    chk("abort_wb_rfwe",  wb_rf_write_en, 1'b0);
    chk("abort_wb_alu",   wb_alu_out,     16'h0000);
    clear_ex();
    @(posedge clk); #1;
    rst = 1'b0;
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 16'hBAD0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_req",   dm_bus.dm_req, 1'b0);
      chk("post_rst_valid", wb_valid,      1'b0);
    end
    dm_bus.dm_ack = 1'b0;
    // Stage must be back in MS_IDLE: a fresh load behaves normally.
    do_op(1, 16'h0044, 16'h0, 19'h00999, 1, 0, 1, 0, 1, 0, 16'hC0DE);
    idle(2);

`ifdef MEM_TIMEOUT_EN
    // Ack in the last allowed cycle completes normally.
    do_op(1, 16'h0200, 16'h0, 19'h01111, 1, 0, 1, 0, 1, 14, 16'h5A5A);
    chk("ack_at_limit_err", mem_err, 1'b0);
    idle(2);
    // No ack at all: abandoned after 15 ACCESS cycles.
    begin
      sb_t e;
      ex_valid = 1; ex_mem_read = 1; ex_alu_out = 16'h0300; ex_instruction = 19'h02222;
      ex_rf_write_en = 1; ex_sel_wb_mem = 1;
      e.alu = 16'h0300; e.md = 16'h0; e.ins = 19'h02222; e.rfwe = 1'b0;
      e.sa = 1'b0; e.sm = 1'b1; e.cyc = cyc + 16;
      sb.push_back(e);
      @(posedge clk); #1;
      for (int i = 0; i < 15; i++) begin
        chk("to_req_held", dm_bus.dm_req, 1'b1);
        chk("to_stall", mem_stall, (i == 14) ? 1'b0 : 1'b1);
        @(posedge clk); #1;
      end
      chk("to_req_drop", dm_bus.dm_req, 1'b0);
      chk("to_mem_err",  mem_err,       1'b1);
      clear_ex();
    end
    do_op(1, 16'h0ABD, 16'h0, 19'h03333, 0, 0, 1, 1, 0, 0, 16'h0);
    idle(2);
`endif

    idle(3);
    chk("sb_drain",    sb.size(), 0);
    chk("mem_err_end", mem_err,   EXP_ERR_END);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, want finished");
    $fatal(1);
  end

endmodule
